// File: rtl/dffe_pipe_pkg.sv
// ============================================================================
// Module   : dffe_pipe_pkg
// Purpose  : Shared constants and helpers for the dffe_pipe register pipeline.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package dffe_pipe_pkg;

  // Upper bounds of the legal parameter ranges.
  localparam int DEPTH_MAX = 16;
  localparam int WIDTH_MAX = 1024;

  // Bits needed to count 0..depth occupied stages.
  function automatic int occ_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/dffe_pipe_if.sv
// ============================================================================
// Module   : dffe_pipe_if
// Purpose  : Valid/ready handshake bundle for the upstream and downstream
//            sides of dffe_pipe.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface dffe_pipe_if #(
  parameter int WIDTH = 8
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  // Environment side: produces input words and consumes output words.
  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data
  );

  // Pipeline side.
  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data
  );

endinterface

`default_nettype wire

// File: rtl/dffe_pipe_stage.sv
// ============================================================================
// Module   : dffe_pipe_stage
// Purpose  : One pipeline stage: a valid flag plus a data register with
//            load / drain / hold behaviour and synchronous reset.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dffe_pipe_stage #(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  wire logic             clk,
  input  wire logic             srst,
  input  wire logic             load,
  input  wire logic             drain,
  input  wire logic [WIDTH-1:0] d_in,
  output logic                  v,
  output logic [WIDTH-1:0]      d
);

  // Load takes priority over drain so a simultaneous drain+refill keeps v set;
  // a pure drain clears v but leaves the stale data in place.
  always_ff @(posedge clk) begin
    if (srst) begin
      v <= 1'b0;
      d <= RST_VAL;
    end else if (load) begin
      v <= 1'b1;
      d <= d_in;
    end else if (drain) begin
      v <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/dffe_pipe.sv
// ============================================================================
// Module   : dffe_pipe
// Purpose  : DEPTH-stage valid/ready register pipeline with a global enable,
//            collapsing bubbles and full throughput (no skid buffer; in_ready
//            is combinational from out_ready).
// Options  : define DFFE_PIPE_OCC_EN to add the registered occupancy port occ.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dffe_pipe
  import dffe_pipe_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter int               DEPTH       = 2,
  parameter bit               EN_POLARITY = 1'b1,
  parameter logic [WIDTH-1:0] RST_VAL     = '0
) (
  input  wire logic CLK,
  input  wire logic SRST,
  input  wire logic EN,
  dffe_pipe_if.slave bus
`ifdef DFFE_PIPE_OCC_EN
  ,
  output logic [occ_width(DEPTH)-1:0] occ
`endif
);

  // Reject illegal parameter sets at elaboration.
  if (WIDTH < 1 || WIDTH > WIDTH_MAX) begin : g_bad_width
    $error("dffe_pipe: WIDTH out of range 1..%0d", WIDTH_MAX);
  end
  if (DEPTH < 1 || DEPTH > DEPTH_MAX) begin : g_bad_depth
    $error("dffe_pipe: DEPTH out of range 1..%0d", DEPTH_MAX);
  end

  logic             en_act;
  logic             in_ready_int;
  logic             out_valid_int;
  logic [DEPTH-1:0] v;
  logic [DEPTH-1:0] free;
  // adv[i] = stage i loads this cycle; adv[DEPTH] = word leaves the pipeline.
  logic [DEPTH:0]   adv;
  logic [WIDTH-1:0] d [DEPTH];

  // Ready/advance chain, resolved from the output back to the input so that
  // any empty stage pulls its predecessor forward in the same cycle.
  always_comb begin
    en_act        = (EN == EN_POLARITY);
    adv           = '0;
    free          = '0;
    out_valid_int = en_act && v[DEPTH-1] && !SRST;
    adv[DEPTH]    = out_valid_int && bus.out_ready;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      free[i] = !v[i] || adv[i+1];
      if (i > 0) begin
        adv[i] = v[i-1] && en_act && free[i];
      end
    end
    // Reset wins over a simultaneous handshake.
    in_ready_int = en_act && free[0] && !SRST;
    adv[0]       = bus.in_valid && in_ready_int;
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic [WIDTH-1:0] stage_in;

    if (i == 0) begin : g_head
      assign stage_in = bus.in_data;
    end else begin : g_body
      assign stage_in = d[i-1];
    end

    dffe_pipe_stage #(
      .WIDTH   (WIDTH),
      .RST_VAL (RST_VAL)
    ) u_stage (
      .clk   (CLK),
      .srst  (SRST),
      .load  (adv[i]),
      .drain (adv[i+1]),
      .d_in  (stage_in),
      .v     (v[i]),
      .d     (d[i])
    );
  end

  assign bus.in_ready  = in_ready_int;
  assign bus.out_valid = out_valid_int;
  assign bus.out_data  = d[DEPTH-1];

`ifdef DFFE_PIPE_OCC_EN
  localparam int OCC_W = occ_width(DEPTH);

  logic [OCC_W-1:0] occ_cnt;

  // Internal stage-to-stage moves keep popcount(v) constant, so only the
  // input accept and output emit change the count.
  always_ff @(posedge CLK) begin
    if (SRST) begin
      occ_cnt <= '0;
    end else if (adv[0] && !adv[DEPTH]) begin
      occ_cnt <= occ_cnt + OCC_W'(1);
    end else if (!adv[0] && adv[DEPTH]) begin
      occ_cnt <= occ_cnt - OCC_W'(1);
    end
  end

  assign occ = occ_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_dffe_pipe.sv
// ============================================================================
// Module   : tb_dffe_pipe
// Purpose  : Self-checking bench for dffe_pipe using three configurations:
//            A (W8,D2), B (W8,D3, active-low EN, RST_VAL A5), C (W32,D4).
// Options  : define DFFE_PIPE_OCC_EN to include the occ checks.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dffe_pipe;

  localparam int NWORDS = 10000;

  logic clk;
  logic a_srst, a_en, b_srst, b_en, c_srst, c_en;

  int checks = 0;
  int errors = 0;

  logic [7:0]  qa [$];
  logic [7:0]  qb [$];
  logic [31:0] qc [$];

  dffe_pipe_if #(.WIDTH(8))  a_bus ();
  dffe_pipe_if #(.WIDTH(8))  b_bus ();
  dffe_pipe_if #(.WIDTH(32)) c_bus ();

`ifdef DFFE_PIPE_OCC_EN
  logic [dffe_pipe_pkg::occ_width(2)-1:0] a_occ;
  logic [dffe_pipe_pkg::occ_width(3)-1:0] b_occ;
  logic [dffe_pipe_pkg::occ_width(4)-1:0] c_occ;
`endif

  dffe_pipe #(.WIDTH(8), .DEPTH(2), .EN_POLARITY(1'b1), .RST_VAL(8'h00)) u_a (
    .CLK(clk), .SRST(a_srst), .EN(a_en), .bus(a_bus)
`ifdef DFFE_PIPE_OCC_EN
    , .occ(a_occ)
`endif
  );

  dffe_pipe #(.WIDTH(8), .DEPTH(3), .EN_POLARITY(1'b0), .RST_VAL(8'hA5)) u_b (
    .CLK(clk), .SRST(b_srst), .EN(b_en), .bus(b_bus)
`ifdef DFFE_PIPE_OCC_EN
    , .occ(b_occ)
`endif
  );

  dffe_pipe #(.WIDTH(32), .DEPTH(4), .EN_POLARITY(1'b1), .RST_VAL(32'h0)) u_c (
    .CLK(clk), .SRST(c_srst), .EN(c_en), .bus(c_bus)
`ifdef DFFE_PIPE_OCC_EN
    , .occ(c_occ)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Move to the next drive point, just after a rising edge.
  task automatic next_drive();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    a_srst = 1'b1; b_srst = 1'b1; c_srst = 1'b1;
    a_en = 1'b1; b_en = 1'b0; c_en = 1'b1;
    a_bus.in_valid = 1'b1; a_bus.in_data = 8'hEE; a_bus.out_ready = 1'b1;
    b_bus.in_valid = 1'b1; b_bus.in_data = 8'hEE; b_bus.out_ready = 1'b1;
    c_bus.in_valid = 1'b1; c_bus.in_data = 32'hEEEE; c_bus.out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if ({a_bus.in_ready, b_bus.in_ready, c_bus.in_ready} !== 3'b000) begin
      errors++;
      $display("FAIL reset_in_ready: got %b expected 000",
               {a_bus.in_ready, b_bus.in_ready, c_bus.in_ready});
    end
    next_drive();
    a_srst = 1'b0; b_srst = 1'b0; c_srst = 1'b0;
    a_bus.in_valid = 1'b0; b_bus.in_valid = 1'b0; c_bus.in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({a_bus.out_valid, b_bus.out_valid, c_bus.out_valid} !== 3'b000) begin
      errors++;
      $display("FAIL reset_out_valid: got %b expected 000",
               {a_bus.out_valid, b_bus.out_valid, c_bus.out_valid});
    end
    checks++;
    if (a_bus.out_data !== 8'h00 || b_bus.out_data !== 8'hA5 || c_bus.out_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_out_data: got %h/%h/%h expected 00/a5/00000000",
               a_bus.out_data, b_bus.out_data, c_bus.out_data);
    end
    checks++;
    if ({a_bus.in_ready, b_bus.in_ready, c_bus.in_ready} !== 3'b111) begin
      errors++;
      $display("FAIL post_reset_in_ready: got %b expected 111",
               {a_bus.in_ready, b_bus.in_ready, c_bus.in_ready});
    end
`ifdef DFFE_PIPE_OCC_EN
    checks++;
    if (a_occ !== '0 || b_occ !== '0 || c_occ !== '0) begin
      errors++;
      $display("FAIL reset_occ: got %0d/%0d/%0d expected 0/0/0", a_occ, b_occ, c_occ);
    end
`endif
    next_drive();
  endtask

  // Config A: three words back to back, latency DEPTH=2, consecutive output.
  task automatic test_back_to_back();
    logic [7:0] words [3];
    int sent = 0, got = 0, acc_cyc = -1, out_cyc = -1, last_out = -1;
    bit consec = 1'b1;
    words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33;
    a_bus.out_ready = 1'b1;
    for (int n = 0; n < 12; n++) begin
      a_bus.in_valid = (sent < 3);
      if (sent < 3) a_bus.in_data = words[sent];
      else          a_bus.in_data = 8'h00;
      @(negedge clk);
      if (a_bus.out_valid && a_bus.out_ready) begin
        checks++;
        if (qa.size() == 0 || a_bus.out_data !== qa[0]) begin
          errors++;
          $display("FAIL b2b_data: got %h expected %h", a_bus.out_data,
                   (qa.size() != 0) ? qa[0] : 8'hxx);
        end
        if (qa.size() != 0) void'(qa.pop_front());
        if (out_cyc < 0) out_cyc = n;
        if (last_out >= 0 && n != last_out + 1) consec = 1'b0;
        last_out = n;
        got++;
      end
      if (a_bus.in_valid && a_bus.in_ready) begin
        qa.push_back(a_bus.in_data);
        if (sent == 0) acc_cyc = n;
        sent++;
      end
      next_drive();
    end
    a_bus.in_valid = 1'b0;
    checks++;
    if (got !== 3) begin
      errors++;
      $display("FAIL b2b_count: got %0d expected 3", got);
    end
    checks++;
    if (out_cyc - acc_cyc !== 2) begin
      errors++;
      $display("FAIL b2b_latency: got %0d expected 2", out_cyc - acc_cyc);
    end
    checks++;
    if (consec !== 1'b1) begin
      errors++;
      $display("FAIL b2b_consecutive: got %b expected 1", consec);
    end
  endtask

  // Config B: stall with out_ready=0, then one simultaneous emit + accept.
  task automatic test_full_stall();
    int idx = 0;
    b_en = 1'b0;
    b_bus.out_ready = 1'b0;
    for (int n = 0; n < 6; n++) begin
      b_bus.in_valid = (idx < 4);
      b_bus.in_data  = 8'(8'hB0 + idx);
      @(negedge clk);
      if (b_bus.in_valid && b_bus.in_ready) begin
        qb.push_back(b_bus.in_data);
        idx++;
      end
      next_drive();
    end
    checks++;
    if (idx !== 3) begin
      errors++;
      $display("FAIL stall_accepts: got %0d expected 3", idx);
    end
    @(negedge clk);
    checks++;
    if (b_bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL stall_in_ready_full: got %b expected 0", b_bus.in_ready);
    end
`ifdef DFFE_PIPE_OCC_EN
    checks++;
    if (b_occ !== 2'd3) begin
      errors++;
      $display("FAIL stall_occ_full: got %0d expected 3", b_occ);
    end
`endif
    next_drive();
    b_bus.out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (b_bus.in_ready !== 1'b1 || b_bus.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL stall_release_hs: got ir=%b ov=%b expected ir=1 ov=1",
               b_bus.in_ready, b_bus.out_valid);
    end
    checks++;
    if (qb.size() == 0 || b_bus.out_data !== qb[0]) begin
      errors++;
      $display("FAIL stall_release_data: got %h expected %h", b_bus.out_data,
               (qb.size() != 0) ? qb[0] : 8'hxx);
    end
    if (b_bus.out_valid && qb.size() != 0) void'(qb.pop_front());
    if (b_bus.in_valid && b_bus.in_ready) qb.push_back(b_bus.in_data);
    next_drive();
    b_bus.out_ready = 1'b0;
    b_bus.in_valid  = 1'b0;
    @(negedge clk);
    checks++;
    if (b_bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL stall_in_ready_after: got %b expected 0", b_bus.in_ready);
    end
`ifdef DFFE_PIPE_OCC_EN
    checks++;
    if (b_occ !== 2'd3) begin
      errors++;
      $display("FAIL stall_occ_after: got %0d expected 3", b_occ);
    end
`endif
    next_drive();
    b_bus.out_ready = 1'b1;
    for (int n = 0; n < 12 && qb.size() != 0; n++) begin
      @(negedge clk);
      if (b_bus.out_valid) begin
        checks++;
        if (b_bus.out_data !== qb[0]) begin
          errors++;
          $display("FAIL stall_drain_data: got %h expected %h", b_bus.out_data, qb[0]);
        end
        void'(qb.pop_front());
      end
      next_drive();
    end
    checks++;
    if (qb.size() != 0) begin
      errors++;
      $display("FAIL stall_drain_left: got %0d words expected 0", qb.size());
    end
  endtask

  // Config B: EN (active-low) deasserted for 5 cycles mid-stream.
  task automatic test_enable_freeze();
    int k = 0, got = 0;
    bit freeze;
    b_bus.out_ready = 1'b1;
    for (int n = 0; n < 20; n++) begin
      freeze = (n >= 5 && n < 10);
      b_en = freeze;
      b_bus.in_valid = (k < 12);
      b_bus.in_data  = 8'(8'hC0 + k);
      @(negedge clk);
      if (freeze) begin
        checks++;
        if (b_bus.in_ready !== 1'b0 || b_bus.out_valid !== 1'b0) begin
          errors++;
          $display("FAIL freeze_hs: got ir=%b ov=%b expected 0/0",
                   b_bus.in_ready, b_bus.out_valid);
        end
        checks++;
        if (qb.size() == 0 || b_bus.out_data !== qb[0]) begin
          errors++;
          $display("FAIL freeze_data: got %h expected %h", b_bus.out_data,
                   (qb.size() != 0) ? qb[0] : 8'hxx);
        end
`ifdef DFFE_PIPE_OCC_EN
        checks++;
        if (int'(b_occ) !== qb.size()) begin
          errors++;
          $display("FAIL freeze_occ: got %0d expected %0d", b_occ, qb.size());
        end
`endif
      end
      if (b_bus.out_valid && b_bus.out_ready) begin
        checks++;
        if (qb.size() == 0 || b_bus.out_data !== qb[0]) begin
          errors++;
          $display("FAIL freeze_stream_data: got %h expected %h", b_bus.out_data,
                   (qb.size() != 0) ? qb[0] : 8'hxx);
        end
        if (qb.size() != 0) void'(qb.pop_front());
        got++;
      end
      if (b_bus.in_valid && b_bus.in_ready) begin
        qb.push_back(b_bus.in_data);
        k++;
      end
      next_drive();
    end
    b_bus.in_valid = 1'b0;
    b_en = 1'b0;
    for (int n = 0; n < 12 && qb.size() != 0; n++) begin
      @(negedge clk);
      if (b_bus.out_valid) begin
        checks++;
        if (b_bus.out_data !== qb[0]) begin
          errors++;
          $display("FAIL freeze_drain_data: got %h expected %h", b_bus.out_data, qb[0]);
        end
        void'(qb.pop_front());
        got++;
      end
      next_drive();
    end
    checks++;
    if (got !== 12 || k !== 12) begin
      errors++;
      $display("FAIL freeze_count: got sent=%0d recv=%0d expected 12/12", k, got);
    end
  endtask

  // Config B: reset a full pipeline with EN inactive, then one word.
  task automatic test_reset_full();
    int acc_cyc = -1, out_cyc = -1, got = 0;
    bit sent = 1'b0;
    b_en = 1'b0;
    b_bus.out_ready = 1'b0;
    for (int n = 0; n < 5; n++) begin
      b_bus.in_valid = 1'b1;
      b_bus.in_data  = 8'(8'hD0 + n);
      @(negedge clk);
      if (b_bus.in_ready) qb.push_back(b_bus.in_data);
      next_drive();
    end
    b_en = 1'b1;
    b_srst = 1'b1;
    b_bus.in_valid = 1'b1;
    b_bus.in_data  = 8'h77;
    b_bus.out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (b_bus.in_ready !== 1'b0 || b_bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rstfull_during: got ir=%b ov=%b expected 0/0",
               b_bus.in_ready, b_bus.out_valid);
    end
    next_drive();
    b_srst = 1'b0;
    b_en = 1'b0;
    b_bus.in_valid = 1'b0;
    qb.delete();
    @(negedge clk);
    checks++;
    if (b_bus.out_valid !== 1'b0 || b_bus.out_data !== 8'hA5) begin
      errors++;
      $display("FAIL rstfull_after: got ov=%b data=%h expected ov=0 data=a5",
               b_bus.out_valid, b_bus.out_data);
    end
`ifdef DFFE_PIPE_OCC_EN
    checks++;
    if (b_occ !== 2'd0) begin
      errors++;
      $display("FAIL rstfull_occ: got %0d expected 0", b_occ);
    end
`endif
    next_drive();
    for (int n = 0; n < 10; n++) begin
      b_bus.in_valid = !sent;
      b_bus.in_data  = 8'h5A;
      @(negedge clk);
      if (b_bus.out_valid) begin
        checks++;
        if (qb.size() == 0 || b_bus.out_data !== qb[0]) begin
          errors++;
          $display("FAIL rstfull_word: got %h expected %h", b_bus.out_data,
                   (qb.size() != 0) ? qb[0] : 8'hxx);
        end
        if (qb.size() != 0) void'(qb.pop_front());
        if (out_cyc < 0) out_cyc = n;
        got++;
      end
      if (b_bus.in_valid && b_bus.in_ready) begin
        qb.push_back(b_bus.in_data);
        acc_cyc = n;
        sent = 1'b1;
      end
      next_drive();
    end
    b_bus.in_valid = 1'b0;
    checks++;
    if (got !== 1 || out_cyc - acc_cyc !== 3) begin
      errors++;
      $display("FAIL rstfull_latency: got count=%0d lat=%0d expected 1/3",
               got, out_cyc - acc_cyc);
    end
  endtask

  // Config C: random valid/ready, scoreboard of order/count, ready model.
  task automatic test_random();
    int sent = 0, got = 0, n = 0;
    bit exp_ir;
    logic [31:0] cur;
    cur = $urandom;
    while (got < NWORDS && n < 60000) begin
      c_bus.in_valid  = (sent < NWORDS) && ($urandom_range(0, 1) == 1);
      c_bus.in_data   = cur;
      c_bus.out_ready = ($urandom_range(0, 1) == 1);
      @(negedge clk);
      exp_ir = (qc.size() < 4) || c_bus.out_ready;
      checks++;
      if (c_bus.in_ready !== exp_ir) begin
        errors++;
        $display("FAIL rand_in_ready: got %b expected %b (held %0d, out_ready %b)",
                 c_bus.in_ready, exp_ir, qc.size(), c_bus.out_ready);
      end
`ifdef DFFE_PIPE_OCC_EN
      checks++;
      if (int'(c_occ) !== qc.size()) begin
        errors++;
        $display("FAIL rand_occ: got %0d expected %0d", c_occ, qc.size());
      end
`endif
      if (c_bus.out_valid && c_bus.out_ready) begin
        checks++;
        if (qc.size() == 0 || c_bus.out_data !== qc[0]) begin
          errors++;
          $display("FAIL rand_data: got %h expected %h", c_bus.out_data,
                   (qc.size() != 0) ? qc[0] : 32'hxxxxxxxx);
        end
        if (qc.size() != 0) void'(qc.pop_front());
        got++;
      end
      if (c_bus.in_valid && c_bus.in_ready) begin
        qc.push_back(cur);
        sent++;
        cur = $urandom;
      end
      next_drive();
      n++;
    end
    c_bus.in_valid = 1'b0;
    checks++;
    if (got !== NWORDS || qc.size() != 0) begin
      errors++;
      $display("FAIL rand_count: got %0d words (%0d left) expected %0d (0 left)",
               got, qc.size(), NWORDS);
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_full_stall();
    test_enable_freeze();
    test_reset_full();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation time limit reached");
  end

endmodule

`default_nettype wire

// File: doc/dffe_pipe.md
DFFE_PIPE -- requirements
Module: dffe_pipe

Interface
REQ-001 Parameter WIDTH, default 8; data width in bits, legal range 1..1024.
REQ-002 Parameter DEPTH, default 2; number of register stages, legal range 1..16.
REQ-003 Parameter EN_POLARITY, default 1; 1 means EN is active-high, 0 means active-low.
REQ-004 Parameter RST_VAL, default 0, WIDTH bits; value loaded into every data register on reset.
REQ-005 One clock; reset is synchronous and active-high.
REQ-006 CLK  input  1  clock; all state updates on the rising edge.
REQ-007 SRST  input  1  synchronous active-high reset.
REQ-008 EN  input  1  global enable; its polarity is set by EN_POLARITY.
REQ-009 in_valid  input  1  upstream data valid.
REQ-010 in_ready  output  1  block accepts in_data this cycle.
REQ-011 in_data  input  WIDTH  upstream data.
REQ-012 out_valid  output  1  out_data valid.
REQ-013 out_ready  input  1  downstream accepts.
REQ-014 out_data  output  WIDTH  data from the last stage.
REQ-015 occ  output  $clog2(DEPTH+1)  count of occupied stages; present only with DFFE_PIPE_OCC_EN.

Function
REQ-016 en_act = (EN == EN_POLARITY).
- When en_act = 0, all stage registers hold their value, in_ready = 0 and out_valid = 0.
REQ-017 Each stage i holds v[i] and d[i].
- Stage i is free when !v[i] || adv[i+1].
- The advance of the stage after the last is out_valid && out_ready.
REQ-018 Stage 0 loads in_data and sets v[0] when in_valid && in_ready.
- Stage i>0 loads d[i-1] when v[i-1] && en_act && stage i is free.
- A stage that is neither loaded nor drained holds d[i] and v[i].
REQ-019 A stage that drains without being refilled clears v[i] and leaves d[i] unchanged.
REQ-020 in_ready = en_act && stage 0 is free.
- in_ready is combinational from out_ready; there is no registered skid.
REQ-021 out_valid = en_act && v[DEPTH-1]; out_data = d[DEPTH-1], unconditionally.
REQ-022 Bubbles collapse: any empty stage accepts data from the stage before it in the same cycle.
REQ-023 Latency from an accept to out_valid is exactly DEPTH cycles when the pipeline is empty and out_ready = 1.
REQ-024 Throughput is 1 transfer per cycle with out_ready = 1; data order is preserved; nothing is duplicated or dropped.
REQ-025 Full (all v = 1) with out_ready = 0: in_ready = 0.
- Full with out_ready = 1: simultaneous accept and emit, occupancy unchanged.
REQ-026 Empty: out_valid = 0, out_data = d[DEPTH-1] (stale or RST_VAL).
REQ-027 EN deasserted mid-stream: the pipeline freezes exactly, and on re-assertion it resumes with no loss.

Reset
REQ-028 SRST = 1 at a rising edge clears every v[i] and loads RST_VAL into every d[i], regardless of EN.
REQ-029 During and after reset: out_valid = 0, out_data = RST_VAL, occ = 0; in_ready is 0 while SRST = 1.
REQ-030 SRST wins over any simultaneous handshake; a word offered in a reset cycle is not accepted.

Configuration
REQ-031 With DFFE_PIPE_OCC_EN defined, occ = popcount(v), registered, updated in the same edge as v.
REQ-032 Without DFFE_PIPE_OCC_EN, the occ port and its counter logic are absent; all other behaviour is identical.

Structure
REQ-033 Package dffe_pipe_pkg holds:
- the DEPTH_MAX = 16 and WIDTH_MAX = 1024 constants;
- the occupancy-width function used for occ.
REQ-034 Sub-module dffe_pipe_stage implements one valid+data register with load/drain/hold and sync reset; it is instantiated DEPTH times.
REQ-035 No latches and no asynchronous logic; a parameter set outside the legal ranges is an elaboration error.

Verification
REQ-036 DEPTH=2, WIDTH=8, EN=1, out_ready=1; send 0x11, 0x22, 0x33 back-to-back.
- out_valid first rises 2 cycles after the 0x11 accept; data emerges in order on consecutive cycles.
REQ-037 DEPTH=3; hold out_ready=0 and offer 4 words.
- 3 words are accepted, then in_ready = 0 and occ = 3.
- out_ready=1 for 1 cycle: one emit and one accept occur in the same cycle, and occ stays 3.
REQ-038 EN_POLARITY=0; drive EN=1 for 5 cycles mid-stream.
- in_ready = 0, out_valid = 0, and all registers are frozen.
- Drive EN=0: the stream resumes with no loss or duplication.
REQ-039 RST_VAL=0xA5; assert SRST with a full pipeline and EN inactive.
- The next cycle shows out_valid = 0, out_data = 0xA5, occ = 0.
- The first post-reset word appears with latency DEPTH.
REQ-040 Random in_valid/out_ready at 50% each over 10k words, DEPTH=4, WIDTH=32.
- A scoreboard confirms order and count.
- in_ready never rises while the pipeline is full and out_ready = 0.
REQ-041 Build without DFFE_PIPE_OCC_EN: the occ port is absent, and REQ-036 to REQ-040 pass unchanged (occ checks skipped).
